// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the single-ported MIPS core.
// Optional illegal-opcode trap: define MC_CTRL_ILLEGAL_TRAP_EN to halt on unsupported instructions.
module mc_ctrl #(
  parameter logic [2:0] ALU_ADD = 3'd0,
  parameter logic [2:0] ALU_SUB = 3'd1,
  parameter logic [2:0] ALU_OR  = 3'd2,
  parameter logic [2:0] ALU_SLL = 3'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic        ext_lui,
  output logic        ext_j_imm26,
  output logic        ext_left_imm5,
  output logic        ext_sleft_imm16,
  output logic [2:0]  state,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_SLL, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
  } cls_t;

  state_t     st;
  cls_t       cls_q;
  cls_t       dec_cls;
  logic [3:0] ext_q;
  logic [3:0] dec_ext;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^instr[25:6];

  always_comb begin
    dec_cls = C_ILL;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h21:   dec_cls = C_ADDU;
          6'h23:   dec_cls = C_SUBU;
          6'h00:   dec_cls = C_SLL;
          default: dec_cls = C_ILL;
        endcase
      end
      6'h0D:   dec_cls = C_ORI;
      6'h0F:   dec_cls = C_LUI;
      6'h23:   dec_cls = C_LW;
      6'h2B:   dec_cls = C_SW;
      6'h04:   dec_cls = C_BEQ;
      6'h02:   dec_cls = C_J;
      6'h03:   dec_cls = C_JAL;
      default: dec_cls = C_ILL;
    endcase
  end

  // Extender select order: {lui, j_imm26, left_imm5, sleft_imm16}
  always_comb begin
    dec_ext = 4'b0000;
    case (dec_cls)
      C_LUI:             dec_ext = 4'b1000;
      C_J, C_JAL:        dec_ext = 4'b0100;
      C_SLL:             dec_ext = 4'b0010;
      C_LW, C_SW, C_BEQ: dec_ext = 4'b0001;
      default:           dec_ext = 4'b0000;
    endcase
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic halt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= S_FETCH;
      cls_q <= C_ILL;
      ext_q <= 4'b0000;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      halt_q <= 1'b0;
`endif
    end else begin
      case (st)
        S_FETCH: if (mem_ack) st <= S_DECODE;
        S_DECODE: begin
          cls_q <= dec_cls;
          ext_q <= dec_ext;
          case (dec_cls)
            C_J:   st <= S_FETCH;
            C_JAL: st <= S_WB;
            C_ILL: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
              st     <= S_HALT;
              halt_q <= 1'b1;
`else
              st <= S_FETCH;
`endif
            end
            default: st <= S_EXEC;
          endcase
        end
        S_EXEC: begin
          case (cls_q)
            C_BEQ:      st <= S_FETCH;
            C_LW, C_SW: st <= S_MEM;
            default:    st <= S_WB;
          endcase
        end
        S_MEM:   if (mem_ack) st <= (cls_q == C_SW) ? S_FETCH : S_WB;
        S_WB:    st <= S_FETCH;
        S_HALT:  st <= S_HALT;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Strobes follow the current state; rst_n low forces everything quiet, which
  // also keeps a late mem_ack from being honoured during reset.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = 2'd0;
    reg_we      = 1'b0;
    reg_dst     = 2'd0;
    wd_sel      = 2'd0;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    {ext_lui, ext_j_imm26, ext_left_imm5, ext_sleft_imm16} = 4'b0000;
    state       = st;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    halted      = halt_q;
`else
    halted      = 1'b0;
`endif
    case (st)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        {ext_lui, ext_j_imm26, ext_left_imm5, ext_sleft_imm16} = dec_ext;
        if (dec_cls == C_J || dec_cls == C_JAL) begin
          pc_we  = 1'b1;
          pc_sel = 2'd2;
        end
      end
      S_EXEC: begin
        {ext_lui, ext_j_imm26, ext_left_imm5, ext_sleft_imm16} = ext_q;
        case (cls_q)
          C_SUBU: alu_op = ALU_SUB;
          C_SLL: begin
            alu_op      = ALU_SLL;
            alu_src_imm = 1'b1;
          end
          C_ORI: begin
            alu_op      = ALU_OR;
            alu_src_imm = 1'b1;
          end
          C_LUI, C_LW, C_SW: alu_src_imm = 1'b1;
          C_BEQ: begin
            alu_op = ALU_SUB;
            pc_we  = alu_zero;
            pc_sel = 2'd1;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      S_MEM: begin
        {ext_lui, ext_j_imm26, ext_left_imm5, ext_sleft_imm16} = ext_q;
        mem_req = 1'b1;
        mem_we  = (cls_q == C_SW);
      end
      S_WB: begin
        {ext_lui, ext_j_imm26, ext_left_imm5, ext_sleft_imm16} = ext_q;
        reg_we = 1'b1;
        case (cls_q)
          C_ADDU, C_SUBU, C_SLL: reg_dst = 2'd1;
          C_LW:                  wd_sel  = 2'd1;
          C_JAL: begin
            reg_dst = 2'd2;
            wd_sel  = 2'd2;
          end
          default: reg_dst = 2'd0;
        endcase
      end
      default: ;
    endcase
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = 2'd0;
      reg_we      = 1'b0;
      reg_dst     = 2'd0;
      wd_sel      = 2'd0;
      alu_op      = 3'd0;
      alu_src_imm = 1'b0;
      {ext_lui, ext_j_imm26, ext_left_imm5, ext_sleft_imm16} = 4'b0000;
      state       = 3'd0;
      halted      = 1'b0;
    end
  end

endmodule
